// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: latch enables/flushes, PC enable, load-use stall and HALT drain FSM.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_mem,
    input  logic             dmemWEN_mem,
    input  logic             memRead_ex,
    input  logic [REG_W-1:0] Rd_ex,
    input  logic [REG_W-1:0] Rs_dec,
    input  logic [REG_W-1:0] Rt_dec,
    input  logic             useRt_dec,
    input  logic             redirect_mem,
    input  logic             halt_dec,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    state_e state_q, state_d;
    logic   dwait, lu;

    assign dwait = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    assign lu    = memRead_ex & (Rd_ex != '0) &
                   ((Rd_ex == Rs_dec) | (useRt_dec & (Rd_ex == Rt_dec)));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:    if (halt_dec & ~dwait & ~redirect_mem & ~lu) state_d = DRAIN;
            // A HALT reaching WB outranks a redirect that arrives in the same cycle.
            DRAIN:  if (halt_wb)                    state_d = HALTED;
                    else if (redirect_mem & ~dwait) state_d = RUN;
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush}          = '1;
        end else if (state_q == HALTED || dwait) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (redirect_mem) begin
            {ifid_flush, idex_flush, exmem_flush} = '1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (~ihit || state_q == DRAIN) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign halt = (state_q == HALTED) & ~RST;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (~pc_en && state_q != HALTED && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (redirect_mem && ~dwait && flush_events_q != '1)
            flush_events_d = flush_events_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; counter tests build only with HAZARD_PERF_CNT_EN.
module tb_hazard_controller;

    localparam int REG_W = 5;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CNT_W = 3;
`endif

    // Observation vector: {pc_en, ifid/idex/exmem/memwb_en, ifid/idex/exmem_flush, halt}
    localparam logic [8:0] O_NORMAL = 9'b11111_000_0;
    localparam logic [8:0] O_RESET  = 9'b00000_111_0;
    localparam logic [8:0] O_LU     = 9'b00111_010_0;
    localparam logic [8:0] O_FREEZE = 9'b00000_000_0;
    localparam logic [8:0] O_REDIR  = 9'b11111_111_0;
    localparam logic [8:0] O_BUBBLE = 9'b01111_100_0;
    localparam logic [8:0] O_HALTED = 9'b00000_000_1;

    logic             CLK = 1'b0;
    logic             RST, ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex;
    logic [REG_W-1:0] Rd_ex, Rs_dec, Rt_dec;
    logic             useRt_dec, redirect_mem, halt_dec, halt_wb;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, halt;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif
    logic [8:0]       obs;
    int               checks = 0;
    int               errors = 0;

    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, halt};

    always #5 CLK = ~CLK;

    hazard_controller #(
        .REG_W(REG_W)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
        .memRead_ex(memRead_ex), .Rd_ex(Rd_ex), .Rs_dec(Rs_dec), .Rt_dec(Rt_dec),
        .useRt_dec(useRt_dec), .redirect_mem(redirect_mem),
        .halt_dec(halt_dec), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halt(halt)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
        memRead_ex = 1'b0; Rd_ex = '0; Rs_dec = '0; Rt_dec = '0; useRt_dec = 1'b0;
        redirect_mem = 1'b0; halt_dec = 1'b0; halt_wb = 1'b0;
    endtask

    task automatic test_reset();
        idle(); RST = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); checks++;
            if (obs !== O_RESET) begin errors++; $display("FAIL reset_hold got %b exp %b", obs, O_RESET); end
            tick();
        end
        RST = 1'b0; ihit = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL reset_release got %b exp %b", obs, O_NORMAL); end
        tick();
    endtask

    task automatic test_load_use();
        memRead_ex = 1'b1; Rd_ex = 5'd8; Rs_dec = 5'd8;
        @(negedge CLK); checks++;
        if (obs !== O_LU) begin errors++; $display("FAIL lu_rs got %b exp %b", obs, O_LU); end
        tick(); memRead_ex = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL lu_clear got %b exp %b", obs, O_NORMAL); end
        tick(); memRead_ex = 1'b1; Rs_dec = 5'd3; Rt_dec = 5'd8; useRt_dec = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_LU) begin errors++; $display("FAIL lu_rt got %b exp %b", obs, O_LU); end
        tick(); useRt_dec = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", obs, O_NORMAL); end
        tick(); Rd_ex = 5'd0; Rs_dec = 5'd0;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL lu_zero_reg got %b exp %b", obs, O_NORMAL); end
        tick(); idle();
    endtask

    task automatic test_dwait();
        dmemREN_mem = 1'b1; dhit = 1'b0; redirect_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); checks++;
            if (obs !== O_FREEZE) begin errors++; $display("FAIL dwait_freeze%0d got %b exp %b", i, obs, O_FREEZE); end
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_REDIR) begin errors++; $display("FAIL dwait_release got %b exp %b", obs, O_REDIR); end
        tick(); idle(); dmemWEN_mem = 1'b1; memRead_ex = 1'b1; Rd_ex = 5'd4; Rs_dec = 5'd4;
        @(negedge CLK); checks++;
        if (obs !== O_FREEZE) begin errors++; $display("FAIL dwait_store_over_lu got %b exp %b", obs, O_FREEZE); end
        tick(); idle();
    endtask

    task automatic test_lu_redirect();
        memRead_ex = 1'b1; Rd_ex = 5'd5; Rs_dec = 5'd5; redirect_mem = 1'b1; ihit = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_REDIR) begin errors++; $display("FAIL lu_redirect got %b exp %b", obs, O_REDIR); end
        tick(); idle(); ihit = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_BUBBLE) begin errors++; $display("FAIL ihit_miss got %b exp %b", obs, O_BUBBLE); end
        memRead_ex = 1'b1; Rd_ex = 5'd6; Rt_dec = 5'd6; useRt_dec = 1'b1; #1;
        checks++;
        if (obs !== O_LU) begin errors++; $display("FAIL lu_over_ihit got %b exp %b", obs, O_LU); end
        tick(); idle();
    endtask

    task automatic test_halt();
        halt_dec = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL halt_dec_run got %b exp %b", obs, O_NORMAL); end
        tick(); halt_dec = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_BUBBLE) begin errors++; $display("FAIL drain got %b exp %b", obs, O_BUBBLE); end
        tick(); redirect_mem = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_REDIR) begin errors++; $display("FAIL drain_redirect got %b exp %b", obs, O_REDIR); end
        tick(); redirect_mem = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL back_to_run got %b exp %b", obs, O_NORMAL); end
        // HALT blocked by a data-cache wait must not start draining
        halt_dec = 1'b1; dmemREN_mem = 1'b1;
        tick(); idle();
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL no_drain_on_dwait got %b exp %b", obs, O_NORMAL); end
        halt_dec = 1'b1;
        tick(); halt_dec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); checks++;
            if (obs !== O_BUBBLE) begin errors++; $display("FAIL drain_wait%0d got %b exp %b", i, obs, O_BUBBLE); end
            tick();
        end
        halt_wb = 1'b1; redirect_mem = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_REDIR) begin errors++; $display("FAIL halt_wb_cycle got %b exp %b", obs, O_REDIR); end
        tick(); idle();
        @(negedge CLK); checks++;
        if (obs !== O_HALTED) begin errors++; $display("FAIL halted got %b exp %b", obs, O_HALTED); end
        tick(); redirect_mem = 1'b1; dmemREN_mem = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_HALTED) begin errors++; $display("FAIL halted_sticky got %b exp %b", obs, O_HALTED); end
        tick(); idle(); RST = 1'b1;
        @(negedge CLK); checks++;
        if (obs !== O_RESET) begin errors++; $display("FAIL halted_reset got %b exp %b", obs, O_RESET); end
        tick(); RST = 1'b0;
        @(negedge CLK); checks++;
        if (obs !== O_NORMAL) begin errors++; $display("FAIL run_after_reset got %b exp %b", obs, O_NORMAL); end
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        idle(); RST = 1'b1;
        tick(); RST = 1'b0; ihit = 1'b0;
        @(negedge CLK); checks++;
        if (stall_cycles !== 3'd0) begin errors++; $display("FAIL cnt_reset got %0d exp 0", stall_cycles); end
        for (int i = 0; i < 4; i++) tick();
        ihit = 1'b1; redirect_mem = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        idle();
        @(negedge CLK); checks++;
        if (stall_cycles !== 3'd4) begin errors++; $display("FAIL stall_cycles got %0d exp 4", stall_cycles); end
        checks++;
        if (flush_events !== 3'd2) begin errors++; $display("FAIL flush_events got %0d exp 2", flush_events); end
        ihit = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ihit = 1'b1; redirect_mem = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        idle(); tick();
        @(negedge CLK); checks++;
        if (stall_cycles !== 3'd7) begin errors++; $display("FAIL stall_sat got %0d exp 7", stall_cycles); end
        checks++;
        if (flush_events !== 3'd7) begin errors++; $display("FAIL flush_sat got %0d exp 7", flush_events); end
    endtask
`endif

    initial begin
        idle(); RST = 1'b1;
        test_reset();
        test_load_use();
        test_dwait();
        test_lu_redirect();
        test_halt();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
